// File: rtl/slc_mem_bridge.sv
// SLC memory/IO bridge: req/ack CPU handshake, wait-stated async SRAM, hex+switch IO window.
// Ports: Clk/Reset; cpu_* handshake; Switches/hex_out IO; ADDR/Data_*/sram_drive/Mem_* to SRAM. Optional: ACCESS_COUNT_EN.
module slc_mem_bridge #(
  parameter int DATA_W                     = 16,
  parameter int CPU_ADDR_W                 = 16,
  parameter int SRAM_ADDR_W                = 20,
  parameter int WAIT_STATES                = 2,
  parameter logic [CPU_ADDR_W-1:0] IO_BASE = 16'hFFF0,
  parameter int NUM_HEX_REGS               = 1,
  parameter logic [CPU_ADDR_W-1:0] SW_ADDR = 16'hFFFF
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [CPU_ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_ack,
  output logic                           cpu_busy,
  input  logic [DATA_W-1:0]              Switches,
  output logic [NUM_HEX_REGS*DATA_W-1:0] hex_out,
  output logic [SRAM_ADDR_W-1:0]         ADDR,
  output logic [DATA_W-1:0]              Data_to_SRAM,
  input  logic [DATA_W-1:0]              Data_from_SRAM,
  output logic                           sram_drive,
  output logic                           Mem_CE,
  output logic                           Mem_UB,
  output logic                           Mem_LB,
  output logic                           Mem_OE,
  output logic                           Mem_WE
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]              cnt;
  logic                    op_we;
  logic                    op_io;
  logic [DATA_W-1:0]       wdata_q;
  logic [NUM_HEX_REGS-1:0] hex_sel;
  logic                    sw_hit;
  logic                    rdc_hit;
  logic                    wrc_hit;
  logic                    io_hit;
  logic [DATA_W-1:0]       io_rdata;

`ifdef ACCESS_COUNT_EN
  localparam logic [CPU_ADDR_W-1:0] RDC_ADDR = SW_ADDR - CPU_ADDR_W'(2);
  localparam logic [CPU_ADDR_W-1:0] WRC_ADDR = SW_ADDR - CPU_ADDR_W'(1);

  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  assign rdc_hit = (cpu_addr == RDC_ADDR);
  assign wrc_hit = (cpu_addr == WRC_ADDR);
`else
  assign rdc_hit = 1'b0;
  assign wrc_hit = 1'b0;
`endif

  // IO window decode and read mux; holes in the window fall through to SRAM.
  always_comb begin
    hex_sel  = '0;
    io_rdata = '0;
    sw_hit   = (cpu_addr == SW_ADDR);
    for (int i = 0; i < NUM_HEX_REGS; i++) begin
      if (cpu_addr == IO_BASE + CPU_ADDR_W'(i)) begin
        hex_sel[i] = 1'b1;
        io_rdata   = io_rdata | hex_out[i*DATA_W +: DATA_W];
      end
    end
    if (sw_hit) io_rdata = io_rdata | Switches;
`ifdef ACCESS_COUNT_EN
    if (rdc_hit) io_rdata = io_rdata | DATA_W'(rd_cnt);
    if (wrc_hit) io_rdata = io_rdata | DATA_W'(wr_cnt);
`endif
  end

  assign io_hit = (|hex_sel) | sw_hit | rdc_hit | wrc_hit;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cpu_req) state_n = io_hit ? DONE : SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are purely a function of state and the latched op.
  always_comb begin
    Mem_CE     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    sram_drive = 1'b0;
    cpu_ack    = 1'b0;
    unique case (state)
      SETUP: begin
        Mem_CE     = 1'b0;
        Mem_OE     = op_we;
        sram_drive = op_we;
      end
      ACCESS: begin
        Mem_CE     = 1'b0;
        Mem_OE     = op_we;
        Mem_WE     = ~op_we;
        sram_drive = op_we;
      end
      DONE: begin
        cpu_ack = 1'b1;
        if (!op_io) begin
          // keep chip enabled and bus driven for data hold
          Mem_CE     = 1'b0;
          sram_drive = op_we;
        end
      end
      default: ;
    endcase
  end

  assign Mem_UB       = Mem_CE;
  assign Mem_LB       = Mem_CE;
  assign cpu_busy     = (state != IDLE);
  assign Data_to_SRAM = wdata_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_we     <= 1'b0;
      op_io     <= 1'b0;
      wdata_q   <= '0;
      ADDR      <= '0;
      cpu_rdata <= '0;
      hex_out   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            op_we   <= cpu_we;
            op_io   <= io_hit;
            wdata_q <= cpu_wdata;
            if (!io_hit) begin
              ADDR <= SRAM_ADDR_W'(cpu_addr);
            end else if (cpu_we) begin
              for (int i = 0; i < NUM_HEX_REGS; i++) begin
                if (hex_sel[i]) hex_out[i*DATA_W +: DATA_W] <= cpu_wdata;
              end
            end else begin
              cpu_rdata <= io_rdata;
            end
          end
        end
        SETUP: cnt <= 4'(WAIT_STATES - 1);
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0 && !op_we) cpu_rdata <= Data_from_SRAM;
        end
        default: ;
      endcase
    end
  end

`ifdef ACCESS_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (state == DONE && !op_io) begin
        if (op_we) wr_cnt <= wr_cnt + 16'd1;
        else       rd_cnt <= rd_cnt + 16'd1;
      end
      if (state == IDLE && cpu_req && cpu_we) begin
        if (rdc_hit) rd_cnt <= '0;
        if (wrc_hit) wr_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/slc_mem_bridge.md
Name: slc_mem_bridge

Overview:
Parametrised memory/IO bridge between an SLC-class CPU core and a single asynchronous external SRAM. It adds a request/acknowledge handshake, programmable SRAM wait states, and a memory-mapped I/O window. The I/O window holds NUM_HEX_REGS display registers and a switch input port. It sits between the datapath's MAR/MDR and the top-level tristate buffer, and drives the hex display driver inputs.

Parameters:
DATA_W, 16, data word width (CPU, SRAM, I/O registers)
CPU_ADDR_W, 16, CPU address width
SRAM_ADDR_W, 20, external SRAM address width; CPU address zero-extended
WAIT_STATES, 2, ACCESS-phase length in cycles; legal 1..15
IO_BASE, 16'hFFF0, base address of display register bank
NUM_HEX_REGS, 1, number of display registers at IO_BASE+i; legal 1..12
SW_ADDR, 16'hFFFF, read-only switch port address

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  access request, sampled only in IDLE
cpu_we  in  1  1=write, 0=read; qualified by cpu_req
cpu_addr  in  CPU_ADDR_W  access address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid in ack cycle, held until next ack
cpu_ack  out  1  one-cycle completion pulse
cpu_busy  out  1  high whenever state != IDLE
Switches  in  DATA_W  switch inputs
hex_out  out  NUM_HEX_REGS*DATA_W  display registers; reg i at bits [i*DATA_W +: DATA_W]
ADDR  out  SRAM_ADDR_W  SRAM address
Data_to_SRAM  out  DATA_W  write data to tristate
Data_from_SRAM  in  DATA_W  read data from tristate
sram_drive  out  1  tristate output enable (drive bus)
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes

Behaviour:
- Reset: state IDLE; all Mem_* = 1; sram_drive = 0; cpu_ack = 0; cpu_busy = 0; cpu_rdata = 0; ADDR = 0; hex_out = 0.
- Address decode at request time:
  - IO hit: address in [IO_BASE, IO_BASE+NUM_HEX_REGS-1] or address == SW_ADDR.
  - Unused addresses in IO_BASE..SW_ADDR map to SRAM.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, cpu_req=1, SRAM address:
  - Latch address, we, and wdata.
  - Go to SETUP. ADDR is updated on that edge.
- SETUP (1 cycle):
  - Mem_CE/UB/LB = 0.
  - Read: Mem_OE = 0.
  - Write: sram_drive = 1, Mem_WE = 1.
  - Go to ACCESS; counter loads WAIT_STATES-1.
- ACCESS (WAIT_STATES cycles):
  - Read: Mem_OE = 0.
  - Write: Mem_WE = 0, sram_drive = 1.
  - Counter decrements; at 0, go to DONE.
  - Read data is captured from Data_from_SRAM on the edge leaving ACCESS.
- DONE (1 cycle):
  - cpu_ack = 1.
  - Mem_WE = 1 and Mem_OE = 1. Mem_CE = 0 and, for writes, sram_drive = 1 to give data hold time.
  - Next state IDLE.
- IDLE, cpu_req=1, IO address:
  - Go straight to DONE; no SRAM strobes.
  - Write to hex reg i: hex_out reg i updates on the same edge.
  - Read of hex reg i returns its value. Read of SW_ADDR returns Switches sampled on that edge.
  - Write to SW_ADDR is ignored, but still acknowledged.
- Latency, request sampled at edge t:
  - SRAM access: ack high in cycle t+2+WAIT_STATES.
  - IO access: ack high in cycle t+1.
- Back-to-back: cpu_req high in the DONE cycle is ignored. It is accepted on the first IDLE cycle, so the minimum gap between acks is one cycle.
- cpu_req and the other CPU inputs are ignored outside IDLE; latched values are used.
- Reset mid-operation: on the next edge the block returns to IDLE with reset values. No ack is issued, and a partial write is abandoned with Mem_WE = 1.
- Mem_UB and Mem_LB always equal Mem_CE (full-word access only).

Optional Feature:
ACCESS_COUNT_EN
- Defined:
  - Two 16-bit wrapping counters: rd_cnt counts completed SRAM reads, wr_cnt counts completed SRAM writes. Each increments in its DONE cycle.
  - Read-only IO addresses: SW_ADDR-2 returns rd_cnt, SW_ADDR-1 returns wr_cnt. Writes to these addresses clear the addressed counter.
  - Both counters clear on Reset. IO accesses are not counted.
- Undefined: no counters exist, and SW_ADDR-2 / SW_ADDR-1 decode to SRAM.

Test Plan:
- Reset, then idle for 5 cycles -> all Mem_* = 1, sram_drive = 0, cpu_ack = 0, hex_out = 0, cpu_busy = 0.
- WAIT_STATES=2: write 16'hBEEF to 16'h0040, req at edge t -> ADDR = 20'h00040; Mem_WE low exactly cycles t+2..t+3; sram_drive high t+1..t+4; ack at t+4.
- Read 16'h0040 with SRAM model returning 16'hBEEF -> Mem_OE low t+1..t+3; ack at t+4 with cpu_rdata = 16'hBEEF.
- Write 16'h1234 to IO_BASE -> ack at t+1, hex_out[15:0] = 16'h1234, no SRAM strobes; read SW_ADDR with Switches = 16'h00A5 -> ack at t+1, cpu_rdata = 16'h00A5.
- Assert Reset during ACCESS of an SRAM write -> next edge: Mem_WE = 1, Mem_CE = 1, state IDLE, no ack pulse; hex_out cleared.
- ACCESS_COUNT_EN: 3 SRAM reads, 2 SRAM writes, 1 IO write -> read of SW_ADDR-2 returns 3, read of SW_ADDR-1 returns 2; after a write to SW_ADDR-2, a read returns 0.
